// File: rtl/fft_w8_pkg.sv
// Shared constants, twiddle-code mapping and round/saturate helpers for the
// parallel-4 FFT W8 twiddle stage.
package fft_w8_pkg;

    localparam int unsigned K_W   = 11;
    localparam logic signed [K_W-1:0] K = -11'sd363;
    localparam int unsigned SHIFT = 9;
    localparam int unsigned LANES = 4;

    typedef enum logic [2:0] {
        W8_0 = 3'd0,
        W8_1 = 3'd1,
        W8_2 = 3'd2,
        W8_3 = 3'd3,
        W8_4 = 3'd4,
        W8_5 = 3'd5,
        W8_6 = 3'd6,
        W8_7 = 3'd7
    } tw_code_e;

    typedef enum logic [1:0] {
        SRC_A,
        SRC_B,
        SRC_P,
        SRC_Q
    } src_e;

    typedef struct packed {
        src_e re_src;
        logic re_neg;
        src_e im_src;
        logic im_neg;
    } tw_op_t;

    // Trivial codes pick a/b (pre-scaled by 2^SHIFT), odd codes pick P/Q.
    function automatic tw_op_t tw_op(input tw_code_e k);
        tw_op_t op;
        op = '{re_src: SRC_A, re_neg: 1'b0, im_src: SRC_B, im_neg: 1'b0};
        unique case (k)
            W8_0: op = '{re_src: SRC_A, re_neg: 1'b0, im_src: SRC_B, im_neg: 1'b0};
            W8_1: op = '{re_src: SRC_P, re_neg: 1'b1, im_src: SRC_Q, im_neg: 1'b1};
            W8_2: op = '{re_src: SRC_B, re_neg: 1'b0, im_src: SRC_A, im_neg: 1'b1};
            W8_3: op = '{re_src: SRC_Q, re_neg: 1'b1, im_src: SRC_P, im_neg: 1'b0};
            W8_4: op = '{re_src: SRC_A, re_neg: 1'b1, im_src: SRC_B, im_neg: 1'b1};
            W8_5: op = '{re_src: SRC_P, re_neg: 1'b0, im_src: SRC_Q, im_neg: 1'b0};
            W8_6: op = '{re_src: SRC_B, re_neg: 1'b1, im_src: SRC_A, im_neg: 1'b0};
            W8_7: op = '{re_src: SRC_Q, re_neg: 1'b0, im_src: SRC_P, im_neg: 1'b1};
        endcase
        return op;
    endfunction

    function automatic logic [2:0] tw_code(input logic [1:0] m, input logic [1:0] p);
        return 3'({1'b0, m} * {1'b0, p});
    endfunction

    function automatic logic signed [63:0] round_q(input logic signed [63:0] v);
        return (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    endfunction

    function automatic logic signed [63:0] sat_hi(input int unsigned nb);
        return (64'sd1 <<< (nb - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                     input int unsigned nb_out);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = round_q(v);
        hi = sat_hi(nb_out);
        lo = -hi - 64'sd1;
        if (r > hi)
            return hi;
        else if (r < lo)
            return lo;
        return r;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] v,
                                     input int unsigned nb_out);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        r  = round_q(v);
        hi = sat_hi(nb_out);
        return (r > hi) || (r < (-hi - 64'sd1));
    endfunction

endpackage

// File: rtl/w8_twiddle_stage_lane.sv
// One complex lane of the W8 twiddle stage: operand select, CSD multiply by K,
// pre-round register, then round/saturate into the output register.
module w8_lane
    import fft_w8_pkg::*;
#(
    parameter int NB_IN  = 23,
    parameter int NB_OUT = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_in,
    input  logic                     en_s1,
    input  logic [2:0]               k,
    input  logic signed [NB_IN-1:0]  re,
    input  logic signed [NB_IN-1:0]  im,
    output logic signed [NB_OUT-1:0] o_re,
    output logic signed [NB_OUT-1:0] o_im,
    output logic                     sat
);

    // Wide enough that negating any product or scaled input is exact.
    localparam int W = NB_IN + 13;

    logic signed [NB_IN:0] sum;
    logic signed [NB_IN:0] dif;
    logic signed [W-1:0]   ax;
    logic signed [W-1:0]   bx;
    logic signed [W-1:0]   px;
    logic signed [W-1:0]   qx;
    logic signed [W-1:0]   sel_re;
    logic signed [W-1:0]   sel_im;
    logic signed [W-1:0]   s1_re;
    logic signed [W-1:0]   s1_im;
    tw_op_t                op;

    // x * K with K = -2^9 + 2^7 + 2^4 + 2^2 + 2^0.
    function automatic logic signed [W-1:0] csd_k(input logic signed [W-1:0] x);
        return (x <<< 7) + (x <<< 4) + (x <<< 2) + x - (x <<< SHIFT);
    endfunction

    function automatic logic signed [W-1:0] pick(input src_e s, input logic neg,
                                                 input logic signed [W-1:0] a_v,
                                                 input logic signed [W-1:0] b_v,
                                                 input logic signed [W-1:0] p_v,
                                                 input logic signed [W-1:0] q_v);
        logic signed [W-1:0] v;
        case (s)
            SRC_A:   v = a_v;
            SRC_B:   v = b_v;
            SRC_P:   v = p_v;
            default: v = q_v;
        endcase
        return neg ? -v : v;
    endfunction

    always_comb begin
        sum    = (NB_IN + 1)'(re) + (NB_IN + 1)'(im);
        dif    = (NB_IN + 1)'(im) - (NB_IN + 1)'(re);
        ax     = W'(re) <<< SHIFT;
        bx     = W'(im) <<< SHIFT;
        px     = csd_k(W'(sum));
        qx     = csd_k(W'(dif));
        op     = tw_op(tw_code_e'(k));
        sel_re = pick(op.re_src, op.re_neg, ax, bx, px, qx);
        sel_im = pick(op.im_src, op.im_neg, ax, bx, px, qx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_re <= '0;
            s1_im <= '0;
            o_re  <= '0;
            o_im  <= '0;
        end else begin
            if (en_in) begin
                s1_re <= sel_re;
                s1_im <= sel_im;
            end
            if (en_s1) begin
                o_re <= NB_OUT'(round_sat(64'(s1_re), NB_OUT));
                o_im <= NB_OUT'(round_sat(64'(s1_im), NB_OUT));
            end
        end
    end

    assign sat = sat_hit(64'(s1_re), NB_OUT) | sat_hit(64'(s1_im), NB_OUT);

endmodule

// File: rtl/w8_twiddle_stage.sv
// Parallel-4 W8 twiddle rotation stage: beat counter, per-lane exponent,
// two-cycle valid pipeline and sticky saturation flag around four w8_lane units.
module w8_twiddle_stage
    import fft_w8_pkg::*;
#(
    parameter int NB_IN  = 23,
    parameter int NB_OUT = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic                      i_sof,
    input  logic [LANES*NB_IN-1:0]    i_re,
    input  logic [LANES*NB_IN-1:0]    i_im,
    output logic                      o_valid,
    output logic [LANES*NB_OUT-1:0]   o_re,
    output logic [LANES*NB_OUT-1:0]   o_im,
    output logic                      o_ovf,
    input  logic                      i_ovf_clr
);

    logic [1:0]       m;
    logic [1:0]       m_used;
    logic             v1;
    logic [LANES-1:0] lane_sat;

    assign m_used = i_sof ? 2'd0 : m;

    always_ff @(posedge clk) begin
        if (rst) begin
            m       <= '0;
            v1      <= 1'b0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (i_valid)
                m <= m_used + 2'd1;
            v1      <= i_valid;
            o_valid <= v1;
            // A saturating beat reaching the output wins over a clear.
            if (v1 && (|lane_sat))
                o_ovf <= 1'b1;
            else if (i_ovf_clr)
                o_ovf <= 1'b0;
        end
    end

    for (genvar p = 0; p < LANES; p++) begin : g_lane
        logic [2:0] lane_k;

        assign lane_k = tw_code(m_used, 2'(p));

        w8_lane #(
            .NB_IN  (NB_IN),
            .NB_OUT (NB_OUT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en_in (i_valid),
            .en_s1 (v1),
            .k     (lane_k),
            .re    (i_re[p*NB_IN +: NB_IN]),
            .im    (i_im[p*NB_IN +: NB_IN]),
            .o_re  (o_re[p*NB_OUT +: NB_OUT]),
            .o_im  (o_im[p*NB_OUT +: NB_OUT]),
            .sat   (lane_sat[p])
        );
    end

endmodule

// File: doc/w8_twiddle_stage.md
# w8_twiddle_stage

Pipelined twiddle-rotation stage for the parallel-4 FFT. It takes four complex lanes per clock and multiplies each lane by an 8th-root twiddle W8^k. The exponent k comes from the lane index and the beat position within a 4-beat frame. The ±1/√2 factors use the team's CSD constant K = −363 (S(11,9), K = −2^9+2^7+2^4+2^2+2^0). Results are rounded and saturated back to sample width, and the stage sits between the radix-2 butterfly outputs and the next butterfly.

## Interface
- NB_IN, 23, input sample width per real/imag component (signed)
- NB_OUT, 23, output sample width per component (signed)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input beat valid
- i_sof  in  1  start of frame; meaningful only with i_valid
- i_re  in  4*NB_IN  lane p real part at bits [p*NB_IN +: NB_IN]
- i_im  in  4*NB_IN  lane p imag part, same packing
- o_valid  out  1  output beat valid
- o_re  out  4*NB_OUT  rotated real parts, same lane packing
- o_im  out  4*NB_OUT  rotated imag parts
- o_ovf  out  1  sticky saturation flag
- i_ovf_clr  in  1  clears o_ovf

## Operation
- Beat counter m (2 bits):
  - On an accepted beat (i_valid=1), m_used = 0 if i_sof else m.
  - The next m is m_used+1 mod 4. m holds when i_valid=0.
- Twiddle exponent per lane: k = (m_used·p) mod 8, for p = 0..3.
- With a = re and b = im: P = K·(a+b), Q = K·(b−a). Sums are NB_IN+1 bits; products are NB_IN+12 bits, full precision.
- Rotation per k, before rounding:
  - k=0 (a,b)·2^9
  - k=1 (−P,−Q)
  - k=2 (b,−a)·2^9
  - k=3 (−Q,P)
  - k=4 (−a,−b)·2^9
  - k=5 (P,Q)
  - k=6 (−b,a)·2^9
  - k=7 (Q,−P)
- Negations are computed one bit wider, so −(−2^(NB_IN−1)) is exact before saturation.
- Round: add 2^8, then arithmetic shift right by 9 (round-half-up).
- Saturate to [−2^(NB_OUT−1), 2^(NB_OUT−1)−1].
- o_ovf is set when any component of any lane in a valid beat saturates.
  - Cleared by rst or i_ovf_clr.
  - If i_ovf_clr and a new saturation event arrive in the same cycle, the set wins.

## Timing
- Stage 1 register: captures the selected rotation value (pre-round, NB_IN+13 bits) and the valid bit.
- Stage 2 register: captures the rounded/saturated outputs and o_valid.
- Latency is 2 cycles from i_valid to o_valid. Throughput is one beat per cycle with no backpressure.
- Bubbles (i_valid=0) propagate as o_valid=0. o_re/o_im hold their last valid value during bubbles.
- Reset values: o_valid=0, o_re=0, o_im=0, o_ovf=0, m=0, stage-1 valid=0.
- Reset mid-stream drops in-flight beats; no o_valid appears for them. After reset, the first accepted beat uses m=0 even without i_sof.
- i_sof asserted with i_valid=0 is ignored.

## Structure
- Package fft_w8_pkg holds:
  - K = −363 and K width 11
  - SHIFT = 9
  - LANES = 4
  - the 3-bit twiddle-code type with k-to-operation mapping
  - the round/saturate function
- Sub-module w8_lane: one lane's operand select, CSD multiply (shift-add only, no `*`), and two pipeline registers. It has an NB_IN/NB_OUT parameter and a 3-bit k input, and is instantiated 4×.
- The top level owns the beat counter, k generation, valid pipeline and o_ovf.

## Test plan
- Trivial lane: i_sof beat with lane0 = (5,−7) gives lane0 out (5,−7) two cycles later, o_valid=1 for exactly one cycle.
- k=1: sof, then beat m=1 with lane1 = (1000,0). Lane1 out is (709,−709), matching round-half-up of ±363000/512.
- Saturation and negation: beat m=2 with lane2 (k=4) = (−4194304,0). Out re = 4194303 and o_ovf=1. o_ovf stays 1 until i_ovf_clr, then reads 0.
- Wrap and mod-8:
  - Four consecutive beats after sof; lane3 on beat m=3 gets k=1.
  - Lane3 = (4194303,4194303) gives re saturated to 4194303 and im = 0.
  - The fifth beat without sof uses m=0.
- Bubbles: valid pattern 1,0,0,1 starting at sof. The second beat is processed with m=1, and o_valid mirrors the input pattern delayed by 2.
- Reset mid-stream: rst asserted while two beats are in flight. No o_valid follows, outputs read 0, and the next beat after release uses m=0.
